// File: rtl/alu_multicycle_if.sv
// Handshake/operand bus between an ALU requester and alu_multicycle.
// ALU_MULTICYCLE_REM_EN adds the remainder signal to the bus.
interface alu_multicycle_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [4:0]       alu_op;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             branch;
    logic             div_zero;
`ifdef ALU_MULTICYCLE_REM_EN
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, alu_op, op1, op2,
        input  busy, done, result, branch, div_zero, remainder
    );
    modport slave (
        input  start, alu_op, op1, op2,
        output busy, done, result, branch, div_zero, remainder
    );
`else
    modport master (
        output start, alu_op, op1, op2,
        input  busy, done, result, branch, div_zero
    );
    modport slave (
        input  start, alu_op, op1, op2,
        output busy, done, result, branch, div_zero
    );
`endif
endinterface

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle arith/shift/logic/compare ops, restoring signed divider.
// Optional feature macro: ALU_MULTICYCLE_REM_EN (exposes the division remainder).
module alu_multicycle #(
    parameter int WIDTH = 16
) (
    input logic           clk,
    input logic           rst_n,
    alu_multicycle_if.slave bus
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic {IDLE, DIV} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             branch_q, branch_d;
    logic             div_zero_q, div_zero_d;

    // Divider working registers (no reset: only meaningful while in DIV)
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             qneg_q, qneg_d;

    logic signed [WIDTH-1:0] a_s, b_s;
    logic [SW-1:0]           shamt;
    logic                    is_div;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_br;
    logic                    alu_dz;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             fits;
    logic [WIDTH-1:0] prem_nx;
    logic [WIDTH-1:0] quo_nx;

`ifdef ALU_MULTICYCLE_REM_EN
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic [WIDTH-1:0] alu_rem;
    logic             rneg_q, rneg_d;
`endif

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        // -MIN wraps back to the MIN bit pattern, which read unsigned is exactly |MIN|
        return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    assign a_s    = bus.op1;
    assign b_s    = bus.op2;
    assign shamt  = bus.op2[SW-1:0];
    assign is_div = (bus.alu_op == 5'b000_11);

    always_comb begin
        alu_res = '0;
        alu_br  = 1'b0;
        alu_dz  = 1'b0;
`ifdef ALU_MULTICYCLE_REM_EN
        alu_rem = '0;
`endif
        case (bus.alu_op)
            5'b000_00: alu_res = a_s + b_s;
            5'b000_01: alu_res = a_s - b_s;
            5'b000_10: alu_res = a_s * b_s;
            5'b000_11: begin
                // Only reached here on divide-by-zero; real divisions go to DIV
                alu_res = '1;
                alu_dz  = 1'b1;
`ifdef ALU_MULTICYCLE_REM_EN
                alu_rem = bus.op1;
`endif
            end
            5'b001_00,
            5'b001_10: alu_res = bus.op1 << shamt;
            5'b001_01: alu_res = bus.op1 >> shamt;
            5'b001_11: alu_res = a_s >>> shamt;
            5'b010_00: alu_res = bus.op1 & bus.op2;
            5'b010_01: alu_res = ~bus.op1;
            5'b010_10: alu_res = bus.op1 | bus.op2;
            5'b010_11: alu_res = bus.op1 ^ bus.op2;
            5'b011_00: alu_res = WIDTH'(a_s < b_s);
            5'b011_01: alu_res = WIDTH'(a_s == b_s);
            5'b101_00: alu_br  = (a_s < b_s);
            5'b101_01: alu_br  = (a_s > b_s);
            5'b101_10: alu_br  = (a_s == b_s);
            default:   alu_res = '0;
        endcase
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits
    assign rem_sh  = {prem_q, quo_q[WIDTH-1]};
    assign fits    = (rem_sh >= {1'b0, dvs_q});
    assign rem_sub = rem_sh[WIDTH-1:0] - dvs_q;
    assign prem_nx = fits ? rem_sub : rem_sh[WIDTH-1:0];
    assign quo_nx  = {quo_q[WIDTH-2:0], fits};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        result_d   = result_q;
        branch_d   = branch_q;
        div_zero_d = div_zero_q;
        prem_d     = prem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        qneg_d     = qneg_q;
`ifdef ALU_MULTICYCLE_REM_EN
        rem_out_d  = rem_out_q;
        rneg_d     = rneg_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (is_div && (bus.op2 != '0)) begin
                        prem_d  = '0;
                        quo_d   = mag(a_s);
                        dvs_d   = mag(b_s);
                        qneg_d  = a_s[WIDTH-1] ^ b_s[WIDTH-1];
`ifdef ALU_MULTICYCLE_REM_EN
                        rneg_d  = a_s[WIDTH-1];
`endif
                        cnt_d   = SW'(WIDTH - 1);
                        state_d = DIV;
                    end else begin
                        done_d     = 1'b1;
                        result_d   = alu_res;
                        branch_d   = alu_br;
                        div_zero_d = alu_dz;
`ifdef ALU_MULTICYCLE_REM_EN
                        rem_out_d  = alu_rem;
`endif
                    end
                end
            end
            DIV: begin
                prem_d = prem_nx;
                quo_d  = quo_nx;
                if (cnt_q == '0) begin
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    result_d   = qneg_q ? WIDTH'(-quo_nx) : quo_nx;
                    branch_d   = 1'b0;
                    div_zero_d = 1'b0;
`ifdef ALU_MULTICYCLE_REM_EN
                    rem_out_d  = rneg_q ? WIDTH'(-prem_nx) : prem_nx;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            result_q   <= '0;
            branch_q   <= 1'b0;
            div_zero_q <= 1'b0;
`ifdef ALU_MULTICYCLE_REM_EN
            rem_out_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            result_q   <= result_d;
            branch_q   <= branch_d;
            div_zero_q <= div_zero_d;
`ifdef ALU_MULTICYCLE_REM_EN
            rem_out_q  <= rem_out_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        prem_q <= prem_d;
        quo_q  <= quo_d;
        dvs_q  <= dvs_d;
        qneg_q <= qneg_d;
`ifdef ALU_MULTICYCLE_REM_EN
        rneg_q <= rneg_d;
`endif
    end

    assign bus.busy     = (state_q == DIV);
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.branch   = branch_q;
    assign bus.div_zero = div_zero_q;
`ifdef ALU_MULTICYCLE_REM_EN
    assign bus.remainder = rem_out_q;
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_alu_multicycle;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    alu_multicycle_if #(.WIDTH(W)) bus ();

    alu_multicycle #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on sign-extended operands
    function automatic void model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic br, output logic dz,
                                  output logic [W-1:0] rm, output int lat);
        int          sa, sb, amt;
        int unsigned ua;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        ua  = 32'(a);
        amt = int'(b[3:0]);
        r = '0; br = 1'b0; dz = 1'b0; rm = '0; lat = 1;
        case (op)
            5'd0:  r = W'(sa + sb);
            5'd1:  r = W'(sa - sb);
            5'd2:  r = W'(sa * sb);
            5'd3: begin
                if (sb == 0) begin
                    r = '1; dz = 1'b1; rm = a;
                end else begin
                    r = W'(sa / sb); rm = W'(sa % sb); lat = W + 1;
                end
            end
            5'd4, 5'd6: r = W'(ua * (32'd1 << amt));
            5'd5:  r = W'(ua / (32'd1 << amt));
            5'd7:  r = W'(sa >>> amt);
            5'd8:  r = a & b;
            5'd9:  r = ~a;
            5'd10: r = a | b;
            5'd11: r = a ^ b;
            5'd12: r = (sa < sb) ? W'(1) : W'(0);
            5'd13: r = (sa == sb) ? W'(1) : W'(0);
            5'd20: br = (sa < sb);
            5'd21: br = (sa > sb);
            5'd22: br = (sa == sb);
            default: r = '0;
        endcase
    endfunction

    // Issue one operation at the current negedge and check it at its done pulse
    task automatic run_op(input string tag, input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] er, erm;
        logic         ebr, edz;
        int           elat, n, nb;
        model(op, a, b, er, ebr, edz, erm, elat);
        n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.start  = 1'b1;
        bus.alu_op = op;
        bus.op1    = a;
        bus.op2    = b;
        @(negedge clk);
        bus.start = 1'b0;
        n  = 1;
        nb = 0;
        while (!bus.done && n < 3 * W) begin
            if (bus.busy) nb++;
            @(negedge clk);
            n++;
        end
        check({tag, ".lat"}, 64'(n), 64'(elat));
        check({tag, ".busy_cycles"}, 64'(nb), 64'(elat - 1));
        check({tag, ".result"}, 64'(bus.result), 64'(er));
        check({tag, ".branch"}, 64'(bus.branch), 64'(ebr));
        check({tag, ".div_zero"}, 64'(bus.div_zero), 64'(edz));
`ifdef ALU_MULTICYCLE_REM_EN
        check({tag, ".remainder"}, 64'(bus.remainder), 64'(erm));
`endif
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h0001;
            4: return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    logic [4:0] ops [22] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                             5'd11, 5'd12, 5'd13, 5'd20, 5'd21, 5'd22, 5'd14, 5'd15, 5'd23,
                             5'd28, 5'd31};

    initial begin
        int n, ndone;
        bus.start  = 1'b0;
        bus.alu_op = '0;
        bus.op1    = '0;
        bus.op2    = '0;
        repeat (3) @(negedge clk);
        check("rst.busy", 64'(bus.busy), 64'd0);
        check("rst.done", 64'(bus.done), 64'd0);
        check("rst.result", 64'(bus.result), 64'd0);
        check("rst.branch", 64'(bus.branch), 64'd0);
        check("rst.div_zero", 64'(bus.div_zero), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("blt", 5'b101_00, 16'hFFFF, 16'h0001);
        run_op("unused", 5'b111_00, 16'h1234, 16'h5678);
        run_op("div_neg", 5'b000_11, 16'hFF9C, 16'h0007);
        run_op("div_by0", 5'b000_11, 16'h0005, 16'h0000);
        run_op("add_after_div0", 5'b000_00, 16'h0001, 16'h0002);

        // Back-to-back single-cycle ops
        bus.start = 1'b1; bus.alu_op = 5'b001_11; bus.op1 = 16'h8000; bus.op2 = 16'd4;
        @(negedge clk);
        check("b2b.sra_done", 64'(bus.done), 64'd1);
        check("b2b.sra_result", 64'(bus.result), 64'hF800);
        bus.alu_op = 5'b000_10; bus.op1 = 16'd300; bus.op2 = 16'd300;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b.mul_done", 64'(bus.done), 64'd1);
        check("b2b.mul_result", 64'(bus.result), 64'h5F90);
        @(negedge clk);
        check("b2b.done_pulse", 64'(bus.done), 64'd0);

        // MIN / -1 with an add held on start while busy
        bus.start = 1'b1; bus.alu_op = 5'b000_11; bus.op1 = 16'h8000; bus.op2 = 16'hFFFF;
        @(negedge clk);
        bus.alu_op = 5'b000_00; bus.op1 = 16'd2; bus.op2 = 16'd3;
        n = 1;
        while (!bus.done && n < 3 * W) begin
            @(negedge clk);
            n++;
        end
        check("minm1.lat", 64'(n), 64'(W + 1));
        check("minm1.result", 64'(bus.result), 64'h8000);
        @(negedge clk);
        bus.start = 1'b0;
        check("minm1.add_done", 64'(bus.done), 64'd1);
        check("minm1.add_result", 64'(bus.result), 64'd5);

        // Reset in the middle of a division
        @(negedge clk);
        bus.start = 1'b1; bus.alu_op = 5'b000_11; bus.op1 = 16'd100; bus.op2 = 16'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("rstdiv.busy_before", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rstdiv.busy", 64'(bus.busy), 64'd0);
        check("rstdiv.result", 64'(bus.result), 64'd0);
        check("rstdiv.done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("rstdiv.no_done", 64'(ndone), 64'd0);
        run_op("add_after_rst", 5'b000_00, 16'd3, 16'd4);

        for (int i = 0; i < 80; i++) begin
            logic [4:0]   op;
            logic [W-1:0] a, b;
            op = ops[$urandom_range(0, 21)];
            a  = rnd_opnd();
            b  = rnd_opnd();
            run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits (legal: 8..64, power of two).
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port start  input  1  operation request, sampled when busy=0.
REQ-005 Port alu_op  input  5  opcode: [4:2] class, [1:0] operation.
REQ-006 Port op1  input  WIDTH  signed operand A, captured with start.
REQ-007 Port op2  input  WIDTH  signed operand B / shift amount, captured with start.
REQ-008 Port busy  output  1  high while a division is iterating.
REQ-009 Port done  output  1  one-cycle pulse: result, branch, div_zero valid.
REQ-010 Port result  output  WIDTH  registered arithmetic/shift/logic/set result.
REQ-011 Port branch  output  1  registered branch-taken flag.
REQ-012 Port div_zero  output  1  registered flag: last operation divided by zero.

Function
REQ-013 Opcodes: 000_00 add, 000_01 sub, 000_10 mul, 000_11 div; 001_00 sll, 001_01 srl, 001_10 sla, 001_11 sra; 010_00 and, 010_01 not(op1), 010_10 or, 010_11 xor; 011_00 slt, 011_01 seq; 101_00 blt, 101_01 bgt, 101_10 beq.
REQ-014 Any other opcode: result=0, branch=0, div_zero=0, done pulses; not an error.
REQ-015 FSM states IDLE, DIV; busy=1 exactly in DIV.
REQ-016 IDLE, start=1, non-div op: outputs updated at that edge, done=1 the following cycle, FSM stays IDLE (latency 1, one op per cycle sustained).
REQ-017 IDLE, start=1, div, op2!=0: operands captured, FSM->DIV, counter loaded WIDTH-1.
REQ-018 DIV: one restoring quotient bit per cycle on magnitudes; counter 0 -> IDLE with quotient on result, done=1 next cycle (latency WIDTH+1 from start).
REQ-019 start while busy=1 is ignored, not queued; start in cycle done=1 is accepted.
REQ-020 add/sub/mul: two's-complement, low WIDTH bits kept, overflow silently wraps.
REQ-021 div: signed, truncation toward zero; quotient negative iff operand signs differ and nonzero; MIN/-1 yields MIN.
REQ-022 div with op2=0: latency 1, result all ones, div_zero=1, no DIV state.
REQ-023 Shifts: amount = op2[log2(WIDTH)-1:0]; sla identical to sll; sra sign-fills; amount 0 passes op1.
REQ-024 slt/seq: signed compare, result 1 or 0 zero-extended; branch=0.
REQ-025 Branch class: branch per signed compare, result=0.
REQ-026 Non-division ops force div_zero=0; branch=0 for non-branch ops.
REQ-027 result, branch, div_zero hold value between done pulses.

Reset
REQ-028 rst_n=0: FSM->IDLE, counter=0, busy=0, done=0, result=0, branch=0, div_zero=0, remainder=0 (if present), immediately.
REQ-029 Reset during DIV aborts division; no done pulse follows; first start after release accepted normally.

Configuration
REQ-030 Macro ALU_MULTICYCLE_REM_EN defined: extra output remainder WIDTH, updated with each div (sign of op1; op1 on divide-by-zero; 0 for other ops).
REQ-031 Macro undefined: remainder port and register absent; all other behaviour identical.

Verification (WIDTH=16)
REQ-032 Reset mid-DIV (cycle 5 of 100/7) -> busy=0, result=0, no done; next add 3+4 -> result 7 after 1 cycle.
REQ-033 start div -100/7 -> busy 16 cycles, done at cycle 17, result -14, remainder -2 (REM_EN), div_zero=0.
REQ-034 start div 5/0 -> done next cycle, result 0xFFFF, div_zero=1; following add clears div_zero.
REQ-035 Back-to-back sra 0x8000 by 4 then mul 300*300 -> done two consecutive cycles, results 0xF800, 0x5F90.
REQ-036 start div 0x8000/-1, then start add asserted while busy -> add ignored, result 0x8000 at done, then add accepted in done cycle.
REQ-037 blt -1,1 -> branch=1, result=0; unused opcode 11100 -> result 0, branch 0, done pulses.
